// File: rtl/inst_cache_dm_if.sv
// Sram-like request/response bundle shared by the CPU side and the downstream
// side of the instruction cache.
interface inst_cache_dm_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (output req, wr, size, addr, wdata,
                  input  rdata, addr_ok, data_ok);
  modport slave  (input  req, wr, size, addr, wdata,
                  output rdata, addr_ok, data_ok);
endinterface

// File: rtl/inst_cache_dm.sv
// Direct-mapped, read-allocate instruction cache, one 32-bit word per line.
// Hits answer locally; misses refill one word downstream; writes pass through.
module inst_cache_dm #(
  parameter int unsigned INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  inst_cache_dm_if.slave         cpu,
  inst_cache_dm_if.master        cache,
  output logic [31:0]            perf_hit_cnt,
  output logic [31:0]            perf_miss_cnt
);
  localparam int unsigned N     = 2 ** INDEX_WIDTH;
  localparam int unsigned TAG_W = 30 - INDEX_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_REFILL,
    S_WPASS,
    S_WRESP
  } state_t;

  state_t state, state_nx;

  logic [N-1:0]           valid;
  logic [TAG_W-1:0]       tag_mem  [N];
  logic [31:0]            data_mem [N];

  logic [31:0]            lat_addr;
  logic [1:0]             lat_size;
  logic [31:0]            lat_wdata;
  logic [31:0]            rdata_q;
  logic                   hit_resp_q;

  logic [INDEX_WIDTH-1:0] cpu_idx, fill_idx;
  logic [TAG_W-1:0]       cpu_tag, fill_tag;
  logic                   hit, rd_hit, rd_miss, wr_start, fill_done;

  assign cpu_idx   = cpu.addr[INDEX_WIDTH+1:2];
  assign cpu_tag   = cpu.addr[31:INDEX_WIDTH+2];
  assign fill_idx  = lat_addr[INDEX_WIDTH+1:2];
  assign fill_tag  = lat_addr[31:INDEX_WIDTH+2];

  assign hit       = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign rd_hit    = (state == S_IDLE) && cpu.req && !cpu.wr && hit;
  assign rd_miss   = (state == S_IDLE) && cpu.req && !cpu.wr && !hit;
  assign wr_start  = (state == S_IDLE) && cpu.req && cpu.wr;
  assign fill_done = (state == S_REFILL) && cache.data_ok;

  // Hit responses come from a register; write responses forward the downstream beat.
  assign cpu.data_ok = hit_resp_q || ((state == S_WRESP) && cache.data_ok);
  assign cpu.rdata   = (state == S_WRESP) ? cache.rdata : rdata_q;

  always_comb begin
    state_nx    = state;
    cpu.addr_ok = 1'b0;
    cache.req   = 1'b0;
    cache.wr    = 1'b0;
    cache.size  = '0;
    cache.addr  = '0;
    cache.wdata = '0;
    case (state)
      S_IDLE: begin
        if (cpu.req) begin
          if (cpu.wr)   state_nx = S_WPASS;
          else if (hit) cpu.addr_ok = 1'b1;
          else          state_nx = S_MISS;
        end
      end
      S_MISS: begin
        cache.req  = 1'b1;
        cache.size = 2'b10;
        cache.addr = lat_addr;
        if (cache.addr_ok) state_nx = S_REFILL;
      end
      S_REFILL: begin
        if (cache.data_ok) state_nx = S_IDLE;
      end
      S_WPASS: begin
        cache.req   = 1'b1;
        cache.wr    = 1'b1;
        cache.size  = lat_size;
        cache.addr  = lat_addr;
        cache.wdata = lat_wdata;
        if (cache.addr_ok) begin
          cpu.addr_ok = 1'b1;
          state_nx    = S_WRESP;
        end
      end
      S_WRESP: begin
        if (cache.data_ok) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      valid         <= '0;
      lat_addr      <= '0;
      lat_size      <= '0;
      lat_wdata     <= '0;
      rdata_q       <= '0;
      hit_resp_q    <= 1'b0;
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else begin
      state      <= state_nx;
      hit_resp_q <= rd_hit;
      if (rd_hit) begin
        rdata_q      <= data_mem[cpu_idx];
        perf_hit_cnt <= perf_hit_cnt + 32'd1;
      end
      if (rd_miss) begin
        lat_addr      <= {cpu.addr[31:2], 2'b00};
        perf_miss_cnt <= perf_miss_cnt + 32'd1;
      end
      if (wr_start) begin
        lat_addr  <= cpu.addr;
        lat_size  <= cpu.size;
        lat_wdata <= cpu.wdata;
      end
      // Flush wins over a refill landing in the same cycle.
      if (flush)                valid           <= '0;
      else if (fill_done)       valid[fill_idx] <= 1'b1;
      else if (wr_start && hit) valid[cpu_idx]  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= cache.rdata;
    end
  end
endmodule

// File: tb/tb_inst_cache_dm.sv
// Directed bench for inst_cache_dm: CPU-side driver tasks plus a fixed-latency
// downstream responder that records every downstream request.
module tb_inst_cache_dm;
  logic        clk = 1'b0;
  logic        resetn;
  logic        flush_tb;
  logic        flush_fill;
  logic        flush;
  logic [31:0] perf_hit_cnt, perf_miss_cnt;

  inst_cache_dm_if cpu_if ();
  inst_cache_dm_if mem_if ();

  assign flush = flush_tb | flush_fill;

  inst_cache_dm #(.INDEX_WIDTH(6)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush         (flush),
    .cpu           (cpu_if.slave),
    .cache         (mem_if.master),
    .perf_hit_cnt  (perf_hit_cnt),
    .perf_miss_cnt (perf_miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // responder state (written only by the responder process)
  int          req_cnt  = 0;
  int          fill_cnt = 0;
  logic [31:0] last_addr  = '0;
  logic [31:0] last_wdata = '0;
  logic        last_wr    = 1'b0;
  logic [1:0]  last_size  = '0;
  // written only by tests
  int          flush_at_fill = -1;

  localparam int LAT = 3;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C08_BFAF;
    return a ^ 32'h1234_5678;
  endfunction

  initial begin : responder
    int  pend;
    logic is_wr;
    pend = 0;
    is_wr = 1'b0;
    mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b0;
    mem_if.rdata   = '0;
    flush_fill     = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      mem_if.addr_ok = 1'b0;
      mem_if.data_ok = 1'b0;
      flush_fill     = 1'b0;
      if (!resetn) begin
        pend = 0;
      end else if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          mem_if.data_ok = 1'b1;
          mem_if.rdata   = is_wr ? 32'h0 : mem_val(last_addr);
          fill_cnt       = fill_cnt + 1;
          flush_fill     = (fill_cnt == flush_at_fill);
        end
      end else if (mem_if.req) begin
        mem_if.addr_ok = 1'b1;
        req_cnt    = req_cnt + 1;
        last_addr  = mem_if.addr;
        last_wr    = mem_if.wr;
        last_size  = mem_if.size;
        last_wdata = mem_if.wdata;
        is_wr      = mem_if.wr;
        pend       = LAT;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1.
  task automatic cpu_access(input logic [31:0] a, input logic w, input logic [31:0] wd,
                            output logic [31:0] d, output int a_cyc, output int d_cyc,
                            output bit to);
    to = 1'b0; a_cyc = 0; d_cyc = 0; d = '0;
    cpu_if.req = 1'b1; cpu_if.wr = w; cpu_if.size = 2'b10;
    cpu_if.addr = a; cpu_if.wdata = wd;
    @(negedge clk);
    while (!cpu_if.addr_ok && !to) begin
      @(negedge clk);
      a_cyc++;
      if (a_cyc > 60) to = 1'b1;
    end
    @(posedge clk); #1;
    cpu_if.req = 1'b0; cpu_if.wr = 1'b0;
    if (!to) begin
      @(negedge clk);
      while (!cpu_if.data_ok && !to) begin
        @(negedge clk);
        d_cyc++;
        if (d_cyc > 60) to = 1'b1;
      end
      d = cpu_if.rdata;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    if ({cpu_if.addr_ok, cpu_if.data_ok, mem_if.req, mem_if.wr} !== 4'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0000",
                        {cpu_if.addr_ok, cpu_if.data_ok, mem_if.req, mem_if.wr});
    end
    checks++;
    if (cpu_if.rdata !== 32'h0 || mem_if.addr !== 32'h0) begin
      fails++; $display("FAIL reset_data: rdata %h addr %h want 0", cpu_if.rdata, mem_if.addr);
    end
    checks++;
    if (perf_hit_cnt !== 32'h0 || perf_miss_cnt !== 32'h0) begin
      fails++; $display("FAIL reset_perf: hit %0d miss %0d want 0", perf_hit_cnt, perf_miss_cnt);
    end
    checks++;
  endtask

  task automatic test_cold_miss;
    logic [31:0] d; int ac, dc; bit to; int r0;
    r0 = req_cnt;
    cpu_access(32'hBFC0_0000, 1'b0, '0, d, ac, dc, to);
    checks++; if (to) begin fails++; $display("FAIL cold_timeout: got timeout want response"); end
    checks++; if (d !== 32'h3C08_BFAF) begin fails++; $display("FAIL cold_data: got %h want 3c08bfaf", d); end
    checks++; if (req_cnt - r0 !== 1) begin fails++; $display("FAIL cold_reqs: got %0d want 1", req_cnt - r0); end
    checks++;
    if (last_addr !== 32'hBFC0_0000 || last_wr !== 1'b0 || last_size !== 2'b10) begin
      fails++; $display("FAIL cold_req_fields: addr %h wr %b size %b want bfc00000 0 10",
                        last_addr, last_wr, last_size);
    end
    checks++; if (perf_miss_cnt !== 32'd1) begin fails++; $display("FAIL cold_miss_cnt: got %0d want 1", perf_miss_cnt); end
  endtask

  task automatic test_repeat_hit;
    logic [31:0] d; int ac, dc; bit to; int r0; logic [31:0] h0;
    r0 = req_cnt; h0 = perf_hit_cnt;
    cpu_access(32'hBFC0_0000, 1'b0, '0, d, ac, dc, to);
    checks++; if (to || ac !== 0 || dc !== 0) begin
      fails++; $display("FAIL hit_latency: to %0d addr_ok wait %0d data wait %0d want 0 0 0", to, ac, dc);
    end
    checks++; if (d !== 32'h3C08_BFAF) begin fails++; $display("FAIL hit_data: got %h want 3c08bfaf", d); end
    checks++; if (req_cnt !== r0) begin fails++; $display("FAIL hit_no_req: got %0d want %0d", req_cnt, r0); end
    checks++; if (perf_hit_cnt - h0 !== 32'd1) begin fails++; $display("FAIL hit_cnt: got +%0d want +1", perf_hit_cnt - h0); end
  endtask

  task automatic test_eviction;
    logic [31:0] d; int ac, dc; bit to; int r0;
    r0 = req_cnt;
    cpu_access(32'hBFC0_0100, 1'b0, '0, d, ac, dc, to);
    checks++; if (to || d !== mem_val(32'hBFC0_0100)) begin
      fails++; $display("FAIL evict_data1: got %h want %h", d, mem_val(32'hBFC0_0100));
    end
    cpu_access(32'hBFC0_0000, 1'b0, '0, d, ac, dc, to);
    checks++; if (to || d !== 32'h3C08_BFAF) begin fails++; $display("FAIL evict_data2: got %h want 3c08bfaf", d); end
    checks++; if (req_cnt - r0 !== 2) begin fails++; $display("FAIL evict_reqs: got %0d want 2", req_cnt - r0); end
    checks++; if (perf_miss_cnt !== 32'd3) begin fails++; $display("FAIL evict_miss_cnt: got %0d want 3", perf_miss_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] b [4]; logic [31:0] d; int ac, dc; bit to; int r0; logic [31:0] h0;
    b[0] = 32'hBFC0_0000; b[1] = 32'hBFC0_0004; b[2] = 32'hBFC0_0008; b[3] = 32'hBFC0_000C;
    for (int i = 0; i < 4; i++) cpu_access(b[i], 1'b0, '0, d, ac, dc, to);
    r0 = req_cnt; h0 = perf_hit_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin cpu_if.req = 1'b1; cpu_if.wr = 1'b0; cpu_if.addr = b[i]; end
      else cpu_if.req = 1'b0;
      @(negedge clk);
      if (i < 4) begin
        checks++; if (cpu_if.addr_ok !== 1'b1) begin fails++; $display("FAIL b2b_addr_ok[%0d]: got %b want 1", i, cpu_if.addr_ok); end
      end
      if (i > 0) begin
        checks++; if (cpu_if.data_ok !== 1'b1 || cpu_if.rdata !== mem_val(b[i-1])) begin
          fails++; $display("FAIL b2b_resp[%0d]: data_ok %b rdata %h want 1 %h", i - 1,
                            cpu_if.data_ok, cpu_if.rdata, mem_val(b[i-1]));
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (req_cnt !== r0 || perf_hit_cnt - h0 !== 32'd4) begin
      fails++; $display("FAIL b2b_counts: reqs +%0d hits +%0d want +0 +4", req_cnt - r0, perf_hit_cnt - h0);
    end
  endtask

  task automatic test_flush;
    logic [31:0] d; int ac, dc; bit to; int r0;
    flush_tb = 1'b1; @(posedge clk); #1; flush_tb = 1'b0;
    r0 = req_cnt;
    cpu_access(32'hBFC0_0000, 1'b0, '0, d, ac, dc, to);
    checks++; if (to || d !== 32'h3C08_BFAF || req_cnt - r0 !== 1) begin
      fails++; $display("FAIL flush_refill: data %h reqs +%0d want 3c08bfaf +1", d, req_cnt - r0);
    end
  endtask

  task automatic test_flush_on_fill;
    logic [31:0] d; int ac, dc; bit to; int r0;
    r0 = req_cnt;
    flush_at_fill = fill_cnt + 1;
    cpu_access(32'hBFC0_0200, 1'b0, '0, d, ac, dc, to);
    flush_at_fill = -1;
    checks++; if (to || d !== mem_val(32'hBFC0_0200)) begin
      fails++; $display("FAIL flushfill_data: got %h want %h", d, mem_val(32'hBFC0_0200));
    end
    checks++; if (req_cnt - r0 !== 2) begin fails++; $display("FAIL flushfill_reqs: got %0d want 2", req_cnt - r0); end
    r0 = req_cnt;
    cpu_access(32'hBFC0_0200, 1'b0, '0, d, ac, dc, to);
    checks++; if (req_cnt !== r0) begin fails++; $display("FAIL flushfill_rehit: reqs +%0d want +0", req_cnt - r0); end
  endtask

  task automatic test_write_pass;
    logic [31:0] d; int ac, dc; bit to; int r0;
    cpu_access(32'h0000_0012, 1'b0, '0, d, ac, dc, to);
    checks++; if (to || d !== mem_val(32'h10) || last_addr !== 32'h10 || last_size !== 2'b10) begin
      fails++; $display("FAIL unaligned_refill: data %h addr %h size %b want %h 00000010 10",
                        d, last_addr, last_size, mem_val(32'h10));
    end
    r0 = req_cnt;
    cpu_access(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, d, ac, dc, to);
    checks++; if (to || req_cnt - r0 !== 1) begin fails++; $display("FAIL wr_handshake: to %0d reqs +%0d want 0 +1", to, req_cnt - r0); end
    checks++; if (last_wr !== 1'b1 || last_addr !== 32'h10 || last_wdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL wr_fields: wr %b addr %h wdata %h want 1 00000010 deadbeef", last_wr, last_addr, last_wdata);
    end
    r0 = req_cnt;
    cpu_access(32'h0000_0010, 1'b0, '0, d, ac, dc, to);
    checks++; if (to || req_cnt - r0 !== 1 || d !== mem_val(32'h10)) begin
      fails++; $display("FAIL wr_invalidate: reqs +%0d data %h want +1 %h", req_cnt - r0, d, mem_val(32'h10));
    end
  endtask

  task automatic test_reset_mid_refill;
    logic [31:0] d; int ac, dc; bit to; int r0, n;
    r0 = req_cnt; n = 0;
    cpu_if.req = 1'b1; cpu_if.wr = 1'b0; cpu_if.addr = 32'h0000_0040;
    while (req_cnt == r0 && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (n >= 40) begin fails++; $display("FAIL rst_refill_start: got timeout want request"); end
    resetn = 1'b0; cpu_if.req = 1'b0;
    @(negedge clk);
    checks++; if ({cpu_if.addr_ok, cpu_if.data_ok, mem_if.req} !== 3'b0 || cpu_if.rdata !== 32'h0) begin
      fails++; $display("FAIL rst_outputs: ctl %b rdata %h want 000 0",
                        {cpu_if.addr_ok, cpu_if.data_ok, mem_if.req}, cpu_if.rdata);
    end
    checks++; if (perf_hit_cnt !== 32'h0 || perf_miss_cnt !== 32'h0) begin
      fails++; $display("FAIL rst_perf: hit %0d miss %0d want 0 0", perf_hit_cnt, perf_miss_cnt);
    end
    @(posedge clk); #1; resetn = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_if.req !== 1'b0) begin fails++; $display("FAIL rst_idle: cache req %b want 0", mem_if.req); end
    r0 = req_cnt;
    cpu_access(32'hBFC0_0000, 1'b0, '0, d, ac, dc, to);
    checks++; if (to || req_cnt - r0 !== 1 || d !== 32'h3C08_BFAF) begin
      fails++; $display("FAIL rst_first_miss: reqs +%0d data %h want +1 3c08bfaf", req_cnt - r0, d);
    end
  endtask

  initial begin
    resetn = 1'b0; flush_tb = 1'b0;
    cpu_if.req = 1'b0; cpu_if.wr = 1'b0; cpu_if.size = 2'b10;
    cpu_if.addr = '0; cpu_if.wdata = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    test_reset();
    @(posedge clk); #1;
    test_cold_miss();
    test_repeat_hit();
    test_eviction();
    test_back_to_back();
    test_flush();
    test_flush_on_fill();
    test_write_pass();
    test_reset_mid_refill();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1, "timeout");
  end
endmodule
